cpu_trace_emitter: RTL and testbench
====================================

CPU_TRACE_EMITTER -- requirements
Module: cpu_trace_emitter

Interface
REQ-001 SHALL have parameter HEX_UPPER, default 0, meaning hex digits a-f are emitted lowercase (0) or uppercase (1).
REQ-002 SHALL have parameter TIME_W, default 14, giving the width of in_time.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1 bit: a trace record is offered.
REQ-006 SHALL have port in_ready, output, 1 bit: the block can accept a record.
REQ-007 SHALL have port in_kind, input, 1 bit: 0 = register write, 1 = memory write.
REQ-008 SHALL have port in_time, input, TIME_W bits: unsigned binary timestamp.
REQ-009 SHALL have port in_pc, input, 32 bits: program counter.
REQ-010 SHALL have port in_grf, input, 5 bits: register number, used when in_kind=0.
REQ-011 SHALL have port in_addr, input, 32 bits: memory address, used when in_kind=1.
REQ-012 SHALL have port in_data, input, 32 bits: written value.
REQ-013 SHALL have port char, output, 8 bits: current ASCII character.
REQ-014 SHALL have port char_valid, output, 1 bit: char is meaningful.
REQ-015 SHALL have port out_ready, input, 1 bit: the sink consumes char on this edge.
REQ-016 SHALL have port line_done, output, 1 bit: one-cycle pulse on the edge where '#' is consumed.

Function
REQ-017 SHALL serialise each accepted record as "^T@PPPPPPPP: $R <= DDDDDDDD#" (kind 0) or "^T@PPPPPPPP: *AAAAAAAA <= DDDDDDDD#" (kind 1), one character per consumption.
REQ-018 SHALL emit T as unsigned decimal with no leading zeros ("0" for zero), 1-4 digits; values above 9999 clamp to 9999.
REQ-019 SHALL emit R as decimal with no leading zeros, 1-2 digits (0..31).
REQ-020 SHALL emit P, A and D as exactly 8 hex digits, most significant first, zero-padded.
REQ-021 SHALL assert in_ready only in IDLE; a record is accepted on an edge where in_valid and in_ready are both 1.
REQ-022 SHALL register all in_* fields at acceptance; later input changes have no effect on the line in progress.
REQ-023 SHALL ignore in_valid while not in IDLE; no queueing.
REQ-024 SHALL present '^' with char_valid=1 in the cycle after acceptance.
REQ-025 SHALL hold char and char_valid stable while out_ready=0, and advance to the next character only on an edge where char_valid and out_ready are both 1.
REQ-026 SHALL sequence through the states IDLE -> CARET -> TIME -> AT -> PC -> COLON -> SPACE -> TAG ('$' or '*') -> ID -> ARROW (" <= ", 4 chars) -> DATA -> HASH -> IDLE, using a digit counter within multi-character states.
REQ-027 SHALL emit exactly one character per cycle when out_ready is held at 1, with no gap cycles inside a line.
REQ-028 SHALL return to IDLE on the edge that consumes '#' and pulse line_done=1 on that same edge.
REQ-029 SHALL raise in_ready the cycle after '#' is consumed, so back-to-back records have exactly one idle cycle between lines.
REQ-030 SHALL drive char=8'h00 and char_valid=0 whenever in IDLE.

Reset
REQ-031 SHALL, while reset=0, immediately force state to IDLE, in_ready=1, char_valid=0, char=8'h00, line_done=0, and clear all counters and registered fields.
REQ-032 SHALL, on reset assertion mid-line, abandon the partial line; the first character after release and a new acceptance SHALL be '^'.

Verification
REQ-033 SHALL verify reset: with reset=0 and arbitrary inputs -> in_ready=1, char_valid=0, char=00, line_done=0.
REQ-034 SHALL verify a register record: kind=0, time=338, pc=0x00003130, grf=2, data=0xffffb528, out_ready=1 -> "^338@00003130: $2 <= ffffb528#" over 30 consecutive cycles, with line_done on the '#' edge.
REQ-035 SHALL verify a memory record: kind=1, time=0, pc=0x00003000, addr=0x88, data=0x1234ABCD -> "^0@00003000: *00000088 <= 1234abcd#"; with HEX_UPPER=1 the output SHALL read "1234ABCD".
REQ-036 SHALL verify backpressure: out_ready=0 for 3 cycles while '@' is presented -> '@' held for 4 cycles, then "0000..." continues with nothing skipped or duplicated.
REQ-037 SHALL verify boundaries: time=12000, grf=31 -> "^9999@...: $31 <= ...#"; a second in_valid held during emission SHALL be accepted only after the idle cycle following '#'.
REQ-038 SHALL verify mid-line reset: reset pulsed low during the PC digits -> char_valid falls immediately; the next record emits a complete line starting with '^'.

Source files
------------

// File: rtl/cpu_trace_emitter.sv
// cpu_trace_emitter: serialises register/memory write records
// into ASCII trace lines, one character per sink handshake.
module cpu_trace_emitter #(
    parameter bit HEX_UPPER = 1'b0,
    parameter int TIME_W    = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_kind,
    input  logic [TIME_W-1:0] in_time,
    input  logic [31:0]       in_pc,
    input  logic [4:0]        in_grf,
    input  logic [31:0]       in_addr,
    input  logic [31:0]       in_data,
    output logic [7:0]        char,
    output logic              char_valid,
    input  logic              out_ready,
    output logic              line_done
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_CARET,
        S_TIME,
        S_AT,
        S_PC,
        S_COLON,
        S_SPACE,
        S_TAG,
        S_ID,
        S_ARROW,
        S_DATA,
        S_HASH
    } state_t;

    state_t      state, state_n;
    logic [2:0]  cnt, cnt_n, last;
    logic        r_kind;
    logic [15:0] r_tbcd;
    logic [1:0]  r_tlast;
    logic [7:0]  r_gbcd;
    logic        r_glast;
    logic [31:0] r_pc, r_addr, r_data;

    logic [13:0] t_clamp;
    logic [15:0] t_bcd;
    logic [1:0]  t_last;
    logic [7:0]  g_bcd;
    logic        g_last;
    logic        accept, fire;
    logic [31:0] sel_word;
    logic [3:0]  nib, tdig, gdig;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        if (n < 4'd10) return 8'h30 + {4'h0, n};
        return (HEX_UPPER ? 8'h37 : 8'h57) + {4'h0, n};
    endfunction

    function automatic logic [7:0] dec_char(input logic [3:0] d);
        return 8'h30 + {4'h0, d};
    endfunction

    assign accept     = in_valid && (state == S_IDLE);
    assign fire       = char_valid && out_ready;
    assign in_ready   = (state == S_IDLE);
    assign char_valid = (state != S_IDLE);
    assign line_done  = (state == S_HASH) && out_ready;

    // Clamp the timestamp and split it and the register number into decimal digits
    always_comb begin
        if (32'(in_time) > 32'd9999) t_clamp = 14'd9999;
        else                         t_clamp = 14'(in_time);
        t_bcd = {4'(t_clamp / 14'd1000),
                 4'((t_clamp / 14'd100) % 14'd10),
                 4'((t_clamp / 14'd10) % 14'd10),
                 4'(t_clamp % 14'd10)};
        if (t_clamp >= 14'd1000)     t_last = 2'd3;
        else if (t_clamp >= 14'd100) t_last = 2'd2;
        else if (t_clamp >= 14'd10)  t_last = 2'd1;
        else                         t_last = 2'd0;
        g_bcd  = {4'(in_grf / 5'd10), 4'(in_grf % 5'd10)};
        g_last = (in_grf >= 5'd10);
    end

    // State, digit counter and captured record
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            r_kind  <= 1'b0;
            r_tbcd  <= '0;
            r_tlast <= '0;
            r_gbcd  <= '0;
            r_glast <= 1'b0;
            r_pc    <= '0;
            r_addr  <= '0;
            r_data  <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (accept) begin
                r_kind  <= in_kind;
                r_tbcd  <= t_bcd;
                r_tlast <= t_last;
                r_gbcd  <= g_bcd;
                r_glast <= g_last;
                r_pc    <= in_pc;
                r_addr  <= in_addr;
                r_data  <= in_data;
            end
        end
    end

    // Next state: walk the field order, stepping the counter inside multi-char fields
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        unique case (state)
            S_TIME:  last = {1'b0, r_tlast};
            S_PC:    last = 3'd7;
            S_ID:    last = r_kind ? 3'd7 : {2'b00, r_glast};
            S_ARROW: last = 3'd3;
            S_DATA:  last = 3'd7;
            default: last = 3'd0;
        endcase
        if (state == S_IDLE) begin
            if (accept) begin
                state_n = S_CARET;
                cnt_n   = '0;
            end
        end else if (fire) begin
            if (cnt == last) begin
                cnt_n   = '0;
                state_n = (state == S_HASH) ? S_IDLE : state_t'(state + 4'd1);
            end else begin
                cnt_n = cnt + 3'd1;
            end
        end
    end

    // Character for the current state and digit position
    always_comb begin
        unique case (state)
            S_ID:    sel_word = r_addr;
            S_DATA:  sel_word = r_data;
            default: sel_word = r_pc;
        endcase
        nib  = 4'(sel_word >> {~cnt, 2'b00});
        tdig = 4'(r_tbcd >> {r_tlast - cnt[1:0], 2'b00});
        gdig = (r_glast && cnt == 3'd0) ? r_gbcd[7:4] : r_gbcd[3:0];
        char = 8'h00;
        unique case (state)
            S_IDLE:  char = 8'h00;
            S_CARET: char = "^";
            S_TIME:  char = dec_char(tdig);
            S_AT:    char = "@";
            S_PC:    char = hex_char(nib);
            S_COLON: char = ":";
            S_SPACE: char = " ";
            S_TAG:   char = r_kind ? "*" : "$";
            S_ID:    char = r_kind ? hex_char(nib) : dec_char(gdig);
            S_ARROW: begin
                unique case (cnt[1:0])
                    2'd1:    char = "<";
                    2'd2:    char = "=";
                    default: char = " ";
                endcase
            end
            S_DATA:  char = hex_char(nib);
            S_HASH:  char = "#";
            default: char = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_cpu_trace_emitter.sv
// tb_cpu_trace_emitter: table-driven lines plus corner sequences,
// expected characters queued at send and popped on each consumption.
module tb_cpu_trace_emitter;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_kind;
    logic [13:0] in_time;
    logic [31:0] in_pc;
    logic [4:0]  in_grf;
    logic [31:0] in_addr;
    logic [31:0] in_data;
    logic        out_ready;

    logic        in_ready0, char_valid0, line_done0;
    logic [7:0]  char0;
    logic        in_ready1, char_valid1, line_done1;
    logic [7:0]  char1;

    int errors = 0;
    int checks = 0;

    byte q[$];
    byte qu[$];

    typedef struct {
        logic        kind;
        logic [13:0] t;
        logic [31:0] pc;
        logic [4:0]  grf;
        logic [31:0] addr;
        logic [31:0] data;
        string       exp;
        int          si;
        int          sn;
    } vec_t;

    vec_t tbl[6];

    cpu_trace_emitter u0 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready0),
        .in_kind(in_kind), .in_time(in_time), .in_pc(in_pc),
        .in_grf(in_grf), .in_addr(in_addr), .in_data(in_data),
        .char(char0), .char_valid(char_valid0),
        .out_ready(out_ready), .line_done(line_done0)
    );

    cpu_trace_emitter #(.HEX_UPPER(1'b1), .TIME_W(14)) u1 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready1),
        .in_kind(in_kind), .in_time(in_time), .in_pc(in_pc),
        .in_grf(in_grf), .in_addr(in_addr), .in_data(in_data),
        .char(char1), .char_valid(char_valid1),
        .out_ready(out_ready), .line_done(line_done1)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input logic k, input logic [13:0] t,
                                input logic [31:0] pc, input logic [4:0] g,
                                input logic [31:0] a, input logic [31:0] d,
                                input string e, input int si, input int sn);
        vec_t v;
        v.kind = k; v.t = t; v.pc = pc; v.grf = g;
        v.addr = a; v.data = d; v.exp = e; v.si = si; v.sn = sn;
        return v;
    endfunction

    function automatic byte up(input byte c);
        return (c >= "a" && c <= "f") ? byte'(c - 8'd32) : c;
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic push(input string s);
        for (int i = 0; i < s.len(); i++) begin
            q.push_back(s[i]);
            qu.push_back(up(s[i]));
        end
    endtask

    task automatic drive(input vec_t v);
        in_kind = v.kind; in_time = v.t; in_pc = v.pc;
        in_grf = v.grf; in_addr = v.addr; in_data = v.data;
    endtask

    task automatic idle_chk(input string name);
        #1;
        chk({name, " char_valid"}, char_valid0, 1'b0);
        chk({name, " char"}, char0, 8'h00);
        chk({name, " in_ready"}, in_ready0, 1'b1);
        chk({name, " line_done"}, line_done0, 1'b0);
        chk({name, " upper char_valid"}, char_valid1, 1'b0);
    endtask

    // Called at a negedge; returns at the negedge showing '^'
    task automatic send(input vec_t v);
        drive(v);
        in_valid = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("in_ready before accept", in_ready0, 1'b1);
        push(v.exp);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain(input int stall_idx, input int stall_n);
        int idx = 0;
        int held = 0;
        int cyc = 0;
        logic rdy;
        byte e, eu;
        while (q.size() > 0 && cyc < 200) begin
            rdy = !(idx == stall_idx && held < stall_n);
            out_ready = rdy;
            #1;
            e = q[0];
            eu = qu[0];
            chk($sformatf("char[%0d]", idx), {char_valid0, char0}, {1'b1, e});
            chk($sformatf("upper char[%0d]", idx), {char_valid1, char1}, {1'b1, eu});
            chk($sformatf("line_done[%0d]", idx), line_done0, rdy && (e == "#"));
            chk("in_ready while busy", in_ready0, 1'b0);
            if (rdy) begin
                void'(q.pop_front());
                void'(qu.pop_front());
                idx++;
            end else begin
                held++;
            end
            cyc++;
            @(negedge clk);
        end
        out_ready = 1'b1;
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain timeout: got %0d chars left want 0", q.size());
            q.delete();
            qu.delete();
        end
    endtask

    initial begin
        tbl[0] = mk(1'b0, 14'd338, 32'h00003130, 5'd2, 32'h0, 32'hffffb528,
                    "^338@00003130: $2 <= ffffb528#", -1, 0);
        tbl[1] = mk(1'b1, 14'd0, 32'h00003000, 5'd7, 32'h00000088, 32'h1234abcd,
                    "^0@00003000: *00000088 <= 1234abcd#", 2, 3);
        tbl[2] = mk(1'b0, 14'd12000, 32'hdeadbeef, 5'd31, 32'h5, 32'h0,
                    "^9999@deadbeef: $31 <= 00000000#", -1, 0);
        tbl[3] = mk(1'b0, 14'd9, 32'h0000ffff, 5'd10, 32'h0, 32'ha5a5a5a5,
                    "^9@0000ffff: $10 <= a5a5a5a5#", 20, 2);
        tbl[4] = mk(1'b1, 14'd1000, 32'h00400000, 5'd0, 32'hfedcba98, 32'h7,
                    "^1000@00400000: *fedcba98 <= 00000007#", -1, 0);
        tbl[5] = mk(1'b0, 14'd99, 32'h11111111, 5'd0, 32'hffffffff, 32'h89abcdef,
                    "^99@11111111: $0 <= 89abcdef#", -1, 0);

        reset = 1'b0;
        in_valid = 1'b1;
        out_ready = 1'b1;
        in_kind = 1'b1;
        in_time = 14'($urandom);
        in_pc = $urandom;
        in_grf = 5'($urandom);
        in_addr = $urandom;
        in_data = $urandom;
        repeat (3) @(negedge clk);
        idle_chk("reset");
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        idle_chk("post reset");

        for (int i = 0; i < 6; i++) begin
            send(tbl[i]);
            drain(tbl[i].si, tbl[i].sn);
            idle_chk($sformatf("idle after line %0d", i));
        end

        // Second record held valid through a line: taken only after the idle cycle
        drive(tbl[2]);
        in_valid = 1'b1;
        push(tbl[2].exp);
        @(negedge clk);
        drive(tbl[5]);
        drain(-1, 0);
        idle_chk("b2b gap");
        push(tbl[5].exp);
        @(negedge clk);
        in_valid = 1'b0;
        drain(-1, 0);
        idle_chk("b2b end");

        // Reset pulse while PC digits are being emitted
        send(tbl[0]);
        repeat (7) @(negedge clk);
        #1;
        chk("pre-reset char_valid", char_valid0, 1'b1);
        reset = 1'b0;
        #1;
        chk("mid reset char_valid", char_valid0, 1'b0);
        chk("mid reset char", char0, 8'h00);
        chk("mid reset in_ready", in_ready0, 1'b1);
        chk("mid reset line_done", line_done0, 1'b0);
        q.delete();
        qu.delete();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        idle_chk("after mid reset");
        send(tbl[3]);
        drain(-1, 0);
        idle_chk("line after reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
